// File: rtl/catch_stack_ctrl_if.sv
// Bundle between the falling-item/tray sources and the catch/stack controller.
// master drives the item and tray stream; slave returns strobes and game status.
interface catch_stack_ctrl_if;
  logic       pause;
  logic       restart;
  logic [9:0] item_x;
  logic [9:0] item_y;
  logic [1:0] item_color;
  logic [9:0] tray_x;

  logic        catch_pulse;
  logic        miss_pulse;
  logic        respawn_req;
  logic [4:0]  stack_height;
  logic [1:0]  top_color;
  logic [1:0]  lives;
  logic [13:0] score;
  logic        game_over;
  logic        win;

  modport master (
    output pause, restart, item_x, item_y, item_color, tray_x,
    input  catch_pulse, miss_pulse, respawn_req, stack_height, top_color,
           lives, score, game_over, win
  );

  modport slave (
    input  pause, restart, item_x, item_y, item_color, tray_x,
    output catch_pulse, miss_pulse, respawn_req, stack_height, top_color,
           lives, score, game_over, win
  );
endinterface

// File: rtl/catch_stack_ctrl.sv
// Catch/miss decision for the falling item against the tray and stack top.
// Tracks stack, lives and score. Optional macro COLOR_BONUS_EN doubles points on a colour match.
module catch_stack_ctrl #(
  parameter int STACK_BASE_Y = 392,
  parameter int BLOCK_H      = 16,
  parameter int ITEM_W       = 32,
  parameter int ITEM_H       = 16,
  parameter int TRAY_W       = 64,
  parameter int MISS_Y       = 400,
  parameter int MAX_STACK    = 16,
  parameter int LIVES_INIT   = 3,
  parameter int CATCH_PTS    = 10
) (
  input logic               clk,
  input logic               rst,
  catch_stack_ctrl_if.slave bus
);

  localparam logic [13:0] SCORE_MAX = 14'd9999;

  typedef enum logic [1:0] {S_PLAY, S_HOLD, S_OVER} state_t;

  state_t      state;
  logic [9:0]  prev_y;
  logic        catch_q, miss_q, resp_q, over_q, win_q;
  logic [4:0]  stack_q;
  logic [1:0]  top_q, lives_q;
  logic [13:0] score_q;

  logic [10:0] item_y_w, prev_y_w, item_x_w, tray_x_w;
  logic [10:0] bottom, prev_bottom, catch_y;
  logic        cross_catch, cross_miss, overlap, wrap;
  logic [13:0] pts, score_add;
  logic [14:0] score_sum;
  logic [4:0]  stack_inc;

  assign item_y_w = {1'b0, bus.item_y};
  assign prev_y_w = {1'b0, prev_y};
  assign item_x_w = {1'b0, bus.item_x};
  assign tray_x_w = {1'b0, bus.tray_x};

  // Catch line rises one block per stacked item; everything is kept in 11 bits.
  assign bottom      = item_y_w + 11'(ITEM_H);
  assign prev_bottom = prev_y_w + 11'(ITEM_H);
  assign catch_y     = 11'(STACK_BASE_Y) - ({6'd0, stack_q} * 11'(BLOCK_H));

  assign cross_catch = (prev_bottom < catch_y) && (bottom >= catch_y);
  assign overlap     = ((item_x_w + 11'(ITEM_W)) > tray_x_w) &&
                       (item_x_w < (tray_x_w + 11'(TRAY_W)));
  assign cross_miss  = (prev_y_w < 11'(MISS_Y)) && (item_y_w >= 11'(MISS_Y));
  assign wrap        = bus.item_y < prev_y;

`ifdef COLOR_BONUS_EN
  assign pts = ((stack_q != 5'd0) && (bus.item_color == top_q)) ?
               14'(2 * CATCH_PTS) : 14'(CATCH_PTS);
`else
  assign pts = 14'(CATCH_PTS);
`endif

  assign score_sum = {1'b0, score_q} + {1'b0, pts};
  assign score_add = (score_sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : score_sum[13:0];
  assign stack_inc = (stack_q >= 5'(MAX_STACK)) ? 5'(MAX_STACK) : stack_q + 5'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_PLAY;
      prev_y  <= '0;
      catch_q <= 1'b0;
      miss_q  <= 1'b0;
      resp_q  <= 1'b0;
      stack_q <= '0;
      top_q   <= '0;
      lives_q <= 2'(LIVES_INIT);
      score_q <= '0;
      over_q  <= 1'b0;
      win_q   <= 1'b0;
    end else if (bus.pause) begin
      // Frozen: state and counters hold, strobes must not linger.
      catch_q <= 1'b0;
      miss_q  <= 1'b0;
      resp_q  <= 1'b0;
    end else begin
      catch_q <= 1'b0;
      miss_q  <= 1'b0;
      resp_q  <= 1'b0;
      prev_y  <= bus.item_y;
      case (state)
        S_PLAY: begin
          if (cross_catch && overlap) begin
            catch_q <= 1'b1;
            resp_q  <= 1'b1;
            stack_q <= stack_inc;
            top_q   <= bus.item_color;
            score_q <= score_add;
            if (stack_inc == 5'(MAX_STACK)) begin
              state  <= S_OVER;
              over_q <= 1'b1;
              win_q  <= 1'b1;
            end else begin
              state <= S_HOLD;
            end
          end else if (cross_miss) begin
            miss_q <= 1'b1;
            if (lives_q <= 2'd1) begin
              lives_q <= 2'd0;
              state   <= S_OVER;
              over_q  <= 1'b1;
            end else begin
              lives_q <= lives_q - 2'd1;
              state   <= S_HOLD;
            end
          end
        end
        // Same item may still sit across the line; wait for it to re-spawn at the top.
        S_HOLD: begin
          if (wrap) state <= S_PLAY;
        end
        S_OVER: begin
          if (bus.restart) begin
            state   <= S_PLAY;
            prev_y  <= '0;
            stack_q <= '0;
            top_q   <= '0;
            lives_q <= 2'(LIVES_INIT);
            score_q <= '0;
            over_q  <= 1'b0;
            win_q   <= 1'b0;
          end
        end
        default: state <= S_PLAY;
      endcase
    end
  end

  assign bus.catch_pulse  = catch_q;
  assign bus.miss_pulse   = miss_q;
  assign bus.respawn_req  = resp_q;
  assign bus.stack_height = stack_q;
  assign bus.top_color    = top_q;
  assign bus.lives        = lives_q;
  assign bus.score        = score_q;
  assign bus.game_over    = over_q;
  assign bus.win          = win_q;

endmodule
